// File: rtl/adc_scan_pkg.sv
// Shared types and constants for the ADC channel-scan sequencer.
package adc_scan_pkg;

  localparam int unsigned ADC_DW = 12;
  localparam int unsigned CH_W   = 3;
  localparam int unsigned NCH    = 8;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_STORE = 2'd3
  } scan_state_e;

endpackage

// File: rtl/adc_ch_next.sv
// Channel walker: lowest enabled channel, next enabled channel above cur
// (wrapping to the lowest), and whether cur is the highest enabled channel.
module adc_ch_next
  import adc_scan_pkg::*;
(
  input  logic [NCH-1:0]  mask,
  input  logic [CH_W-1:0] cur,
  output logic [CH_W-1:0] first_ch,
  output logic [CH_W-1:0] next_ch,
  output logic            is_last
);

  logic [CH_W-1:0] idx;
  logic [CH_W-1:0] above;
  logic            found;

  // Scan from the top down so the last hit is the lowest qualifying channel.
  always_comb begin
    idx      = '0;
    above    = '0;
    found    = 1'b0;
    first_ch = '0;
    for (int unsigned i = 0; i < NCH; i++) begin
      idx = CH_W'(NCH - 1 - i);
      if (mask[idx]) begin
        first_ch = idx;
      end
      if (mask[idx] && (idx > cur)) begin
        above = idx;
        found = 1'b1;
      end
    end
    next_ch = found ? above : first_ch;
    is_last = ~found;
  end

endmodule

// File: rtl/adc_scan_ctrl.sv
// Channel-scan sequencer for the 8-channel SPI ADC. Issues one frame per
// enabled channel plus a leading dummy frame, and re-tags each frame's data
// with the channel addressed in the previous frame.
module adc_scan_ctrl
  import adc_scan_pkg::*;
#(
  parameter int unsigned SCAN_PERIOD = 50000,
  parameter int unsigned TIMEOUT     = 1023
)
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              scan_en,
  input  logic              one_shot,
  input  logic [NCH-1:0]    ch_mask,
  output logic              adc_start,
  output logic [CH_W-1:0]   adc_channel,
  input  logic              adc_done,
  input  logic [ADC_DW-1:0] adc_data,
  output logic              res_wr,
  output logic [CH_W-1:0]   res_ch,
  output logic [ADC_DW-1:0] res_data,
  output logic              scan_done,
  output logic              busy,
  output logic              overrun,
  output logic              timeout_err
);

  localparam int unsigned PCNT_W  = $clog2(SCAN_PERIOD);
  localparam int unsigned TCNT_W  = $clog2(TIMEOUT);
  localparam int unsigned FRAME_W = $clog2(NCH + 1);
  localparam logic [PCNT_W-1:0] PCNT_LAST = PCNT_W'(SCAN_PERIOD - 1);
  localparam logic [TCNT_W-1:0] TCNT_LAST = TCNT_W'(TIMEOUT - 1);

  scan_state_e         state_q, state_d;
  logic [PCNT_W-1:0]   pcnt_q, pcnt_d;
  logic [TCNT_W-1:0]   tcnt_q, tcnt_d;
  logic [FRAME_W-1:0]  frame_q, frame_d;
  logic [NCH-1:0]      mask_q, mask_d;
  logic [CH_W-1:0]     addr_q, addr_d;
  logic [CH_W-1:0]     prev_q, prev_d;
  logic                final_q, final_d;
  logic [CH_W-1:0]     res_ch_q, res_ch_d;
  logic [ADC_DW-1:0]   res_data_q, res_data_d;
  logic                scan_done_q, scan_done_d;
  logic                timeout_err_q, timeout_err_d;

  logic                tick;
  logic                trig;
  logic [NCH-1:0]      walk_mask;
  logic [CH_W-1:0]     first_ch;
  logic [CH_W-1:0]     next_ch;
  logic                is_last;

  // In IDLE the walker looks at the live mask to pick the first channel at
  // accept; during a scan it only sees the snapshot.
  assign walk_mask = (state_q == S_IDLE) ? ch_mask : mask_q;

  adc_ch_next u_ch_next (
    .mask     (walk_mask),
    .cur      (addr_q),
    .first_ch (first_ch),
    .next_ch  (next_ch),
    .is_last  (is_last)
  );

  // Periodic trigger counter: free-runs while enabled, parked at zero otherwise.
  always_comb begin
    tick   = scan_en && (pcnt_q == PCNT_LAST);
    pcnt_d = pcnt_q + 1'b1;
    if (!scan_en || tick) begin
      pcnt_d = '0;
    end
  end

  assign trig = tick | one_shot;

  // Scan FSM next-state and datapath updates.
  always_comb begin
    state_d       = state_q;
    tcnt_d        = tcnt_q;
    frame_d       = frame_q;
    mask_d        = mask_q;
    addr_d        = addr_q;
    prev_d        = prev_q;
    final_d       = final_q;
    res_ch_d      = res_ch_q;
    res_data_d    = res_data_q;
    scan_done_d   = 1'b0;
    timeout_err_d = timeout_err_q;

    case (state_q)
      S_IDLE: begin
        if (trig && (ch_mask != '0)) begin
          mask_d        = ch_mask;
          addr_d        = first_ch;
          frame_d       = '0;
          final_d       = 1'b0;
          timeout_err_d = 1'b0;
          state_d       = S_ISSUE;
        end
      end
      S_ISSUE: begin
        tcnt_d  = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (adc_done) begin
          prev_d = addr_q;
          if (frame_q != '0) begin
            res_ch_d   = prev_q;
            res_data_d = adc_data;
          end
          state_d = S_STORE;
        end else if (tcnt_q == TCNT_LAST) begin
          timeout_err_d = 1'b1;
          state_d       = S_IDLE;
        end else begin
          tcnt_d = tcnt_q + 1'b1;
        end
      end
      S_STORE: begin
        // final_q marks the frame that re-addressed the first channel after
        // the walk wrapped; its result closes the scan.
        if (final_q) begin
          scan_done_d = 1'b1;
          state_d     = S_IDLE;
        end else begin
          addr_d  = next_ch;
          final_d = is_last;
          frame_d = frame_q + 1'b1;
          state_d = S_ISSUE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      pcnt_q        <= '0;
      tcnt_q        <= '0;
      frame_q       <= '0;
      mask_q        <= '0;
      addr_q        <= '0;
      prev_q        <= '0;
      final_q       <= 1'b0;
      res_ch_q      <= '0;
      res_data_q    <= '0;
      scan_done_q   <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      pcnt_q        <= pcnt_d;
      tcnt_q        <= tcnt_d;
      frame_q       <= frame_d;
      mask_q        <= mask_d;
      addr_q        <= addr_d;
      prev_q        <= prev_d;
      final_q       <= final_d;
      res_ch_q      <= res_ch_d;
      res_data_q    <= res_data_d;
      scan_done_q   <= scan_done_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign adc_start   = (state_q == S_ISSUE);
  assign adc_channel = addr_q;
  assign res_wr      = (state_q == S_STORE) && (frame_q != '0);
  assign res_ch      = res_ch_q;
  assign res_data    = res_data_q;
  assign scan_done   = scan_done_q;
  assign busy        = (state_q != S_IDLE);
  assign overrun     = trig && (state_q != S_IDLE);
  assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_adc_scan_ctrl.sv
// Scoreboard bench for adc_scan_ctrl with an SPI frame-engine model.
module tb_adc_scan_ctrl;

  localparam int P         = 2000;
  localparam int TO        = 1023;
  localparam int FRAME_LAT = 374;

  logic        clk, rst_n, scan_en, one_shot;
  logic [7:0]  ch_mask;
  logic        adc_start, adc_done;
  logic [2:0]  adc_channel;
  logic [11:0] adc_data;
  logic        res_wr, scan_done, busy, overrun, timeout_err;
  logic [2:0]  res_ch;
  logic [11:0] res_data;

  adc_scan_ctrl #(.SCAN_PERIOD(P), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .scan_en(scan_en), .one_shot(one_shot),
    .ch_mask(ch_mask), .adc_start(adc_start), .adc_channel(adc_channel),
    .adc_done(adc_done), .adc_data(adc_data), .res_wr(res_wr),
    .res_ch(res_ch), .res_data(res_data), .scan_done(scan_done),
    .busy(busy), .overrun(overrun), .timeout_err(timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  logic [2:0]  exp_ch_q[$];
  logic [14:0] exp_res_q[$];
  int          exp_done = 0;
  int          exp_ovr  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // ---------------- SPI frame-engine model ----------------
  int          start_cnt = 0;
  int          withhold_idx = -1;
  int          last_start_cyc = 0;
  logic [2:0]  model_prev = 3'd0;
  logic [11:0] pend_q[$];

  task automatic send_done();
    repeat (FRAME_LAT) @(negedge clk);
    adc_data = pend_q.pop_front();
    adc_done = 1'b1;
    @(negedge clk);
    adc_done = 1'b0;
    adc_data = 12'($urandom);
  endtask

  always @(negedge clk) begin
    if (rst_n && adc_start) begin
      start_cnt++;
      last_start_cyc = cyc;
      if (start_cnt != withhold_idx) begin
        pend_q.push_back({model_prev, 9'h0A5});
        fork
          send_done();
        join_none
      end
      model_prev = adc_channel;
    end
  end

  // ---------------- Monitor ----------------
  always @(negedge clk) begin
    if (rst_n) begin
      if (adc_start) begin
        if (exp_ch_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL adc_start_unexpected actual=ch%0d required=none", adc_channel);
        end else begin
          chk("adc_channel", 32'(adc_channel), 32'(exp_ch_q.pop_front()));
        end
      end
      if (res_wr) begin
        if (exp_res_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL res_wr_unexpected actual=ch%0d/%0h required=none", res_ch, res_data);
        end else begin
          chk("result", 32'({res_ch, res_data}), 32'(exp_res_q.pop_front()));
        end
      end
      if (scan_done) begin
        checks++;
        if (exp_done == 0) begin
          errors++;
          $display("FAIL scan_done_unexpected actual=1 required=0");
        end else begin
          exp_done--;
        end
        chk("busy_at_scan_done", 32'(busy), 32'd0);
      end
      if (overrun) begin
        checks++;
        if (exp_ovr == 0) begin
          errors++;
          $display("FAIL overrun_unexpected actual=1 required=0");
        end else begin
          exp_ovr--;
        end
      end
    end
  end

  // ---------------- Reference model of one scan ----------------
  task automatic push_scan(input logic [7:0] m);
    logic [2:0] chs[$];
    for (int i = 0; i < 8; i++) begin
      if (m[i]) chs.push_back(3'(i));
    end
    foreach (chs[k]) exp_ch_q.push_back(chs[k]);
    exp_ch_q.push_back(chs[0]);
    foreach (chs[k]) exp_res_q.push_back({chs[k], chs[k], 9'h0A5});
    exp_done++;
  endtask

  task automatic wait_idle(input string name, input int budget);
    int n = 0;
    while (busy && n < budget) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (busy) begin
      errors++;
      $display("FAIL %s_idle_wait actual=busy required=idle", name);
    end
  endtask

  task automatic check_drained(input string name);
    chk({name, "_ch_left"},   32'(exp_ch_q.size()),  32'd0);
    chk({name, "_res_left"},  32'(exp_res_q.size()), 32'd0);
    chk({name, "_done_left"}, 32'(exp_done),         32'd0);
    chk({name, "_ovr_left"},  32'(exp_ovr),          32'd0);
  endtask

  task automatic run_scan(input string name, input logic [7:0] m, input bit scramble);
    ch_mask = m;
    push_scan(m);
    one_shot = 1'b1;
    @(negedge clk);
    one_shot = 1'b0;
    chk({name, "_busy_accept"}, 32'(busy), 32'd1);
    chk({name, "_terr_clear"}, 32'(timeout_err), 32'd0);
    if (scramble) ch_mask = 8'($urandom);
    wait_idle(name, 9 * 380 + 50);
    @(negedge clk);
    check_drained(name);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1);
  end

  // ---------------- Stimulus ----------------
  initial begin
    int c0, t1, t2, n, seen;
    rst_n = 1'b0; scan_en = 1'b0; one_shot = 1'b0; ch_mask = 8'h00;
    adc_done = 1'b0; adc_data = 12'h000;
    repeat (3) @(negedge clk);
    chk("reset_outputs", 32'({adc_start, adc_channel, res_wr, res_ch, res_data,
                              scan_done, busy, overrun, timeout_err}), 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    run_scan("mask05", 8'h05, 1'b0);
    run_scan("maskFF", 8'hFF, 1'b0);
    for (int r = 0; r < 4; r++) begin
      run_scan("rand", 8'($urandom_range(1, 255)), 1'b1);
    end

    // mask==0: trigger ignored
    ch_mask = 8'h00;
    one_shot = 1'b1;
    @(negedge clk);
    one_shot = 1'b0;
    seen = 0;
    repeat (20) begin
      if (busy) seen = 1;
      @(negedge clk);
    end
    chk("mask0_busy", 32'(seen), 32'd0);

    // periodic scans with an overrun one_shot
    ch_mask = 8'h01;
    for (int k = 0; k < 3; k++) push_scan(8'h01);
    exp_ovr = 1;
    scan_en = 1'b1;
    c0 = cyc;
    for (int k = 0; k < 3; k++) begin
      n = 0;
      while (!busy && n < P + 10) begin
        @(negedge clk);
        n++;
      end
      chk("period_start", 32'(cyc - c0), 32'((k + 1) * P));
      if (k == 0) begin
        repeat (100) @(negedge clk);
        one_shot = 1'b1;
        @(negedge clk);
        one_shot = 1'b0;
      end
      if (k == 2) begin
        repeat (100) @(negedge clk);
        scan_en = 1'b0;
      end
      wait_idle("period", 1000);
    end
    seen = 0;
    repeat (2500) begin
      if (busy) seen = 1;
      @(negedge clk);
    end
    chk("period_stopped", 32'(seen), 32'd0);
    check_drained("period");

    // timeout on frame 1
    ch_mask = 8'h03;
    exp_ch_q.push_back(3'd0);
    exp_ch_q.push_back(3'd1);
    withhold_idx = start_cnt + 2;
    one_shot = 1'b1;
    @(negedge clk);
    one_shot = 1'b0;
    n = 0;
    while (start_cnt < withhold_idx && n < 1000) begin
      @(negedge clk);
      n++;
    end
    t1 = last_start_cyc;
    wait_idle("timeout", TO + 50);
    t2 = cyc;
    checks++;
    if ((t2 - t1) < TO || (t2 - t1) > TO + 2) begin
      errors++;
      $display("FAIL timeout_latency actual=%0d required=%0d..%0d", t2 - t1, TO, TO + 2);
    end
    chk("timeout_err_set", 32'(timeout_err), 32'd1);
    repeat (5) @(negedge clk);
    check_drained("timeout");
    run_scan("after_timeout", 8'h81, 1'b0);

    // async reset mid-WAIT
    ch_mask = 8'h01;
    push_scan(8'h01);
    one_shot = 1'b1;
    @(negedge clk);
    one_shot = 1'b0;
    repeat (100) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midreset_outputs", 32'({adc_start, adc_channel, res_wr, res_ch, res_data,
                                 scan_done, busy, overrun, timeout_err}), 32'd0);
    exp_ch_q.delete();
    exp_res_q.delete();
    exp_done = 0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (400) @(negedge clk);
    chk("post_reset_busy", 32'(busy), 32'd0);
    check_drained("reset");
    run_scan("recover", 8'($urandom_range(1, 255)), 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
